secuenciador_rom: RTL and testbench

Address sequencer that sits directly upstream of the 4x4 ROM (`rom4x4`). On a start pulse it walks a programmable address range, drives `address` into the ROM and captures the combinational `datos` it returns. It then presents each word downstream through a valid/ready handshake that supports backpressure. It supports single-pass and continuous-loop modes, and an abort input.

---
 rtl/secuenciador_rom_pkg.sv | 13 +
 rtl/rom4x4.sv | 24 ++
 rtl/secuenciador_rom.sv | 112 +++++++++++
 tb/tb_secuenciador_rom.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secuenciador_rom_pkg.sv
// Shared types and default widths for the ROM address sequencer and its ROM.
package secuenciador_rom_pkg;

    localparam int AW_DEF = 2;
    localparam int DW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LEER     = 2'd1,
        ENTREGAR = 2'd2
    } estado_t;

endpackage

// File: rtl/rom4x4.sv
// 4-word x 4-bit combinational ROM holding one-hot words {1, 2, 4, 8}.
module rom4x4
    import secuenciador_rom_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic [AW-1:0] address,
    output logic [DW-1:0] datos
);

    // Pure lookup; the sequencer registers the result.
    always_comb begin
        datos = '0;
        case (address)
            AW'(0):  datos = DW'(4'h1);
            AW'(1):  datos = DW'(4'h2);
            AW'(2):  datos = DW'(4'h4);
            AW'(3):  datos = DW'(4'h8);
            default: datos = '0;
        endcase
    end

endmodule

// File: rtl/secuenciador_rom.sv
// Walks a programmable (wrapping) address range over the ROM and hands each
// word downstream on a valid/ready handshake. Single-pass or loop, with abort.
module secuenciador_rom
    import secuenciador_rom_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          parar,
    input  logic          modo_ciclo,
    input  logic [AW-1:0] dir_ini,
    input  logic [AW-1:0] dir_fin,
    output logic [AW-1:0] address,
    input  logic [DW-1:0] datos_rom,
    output logic [DW-1:0] dato,
    output logic          valido,
    input  logic          listo,
    output logic          ocupado,
    output logic          fin
);

    estado_t       estado, estado_nxt;
    logic [AW-1:0] ptr, ini_q, fin_q;
    logic          modo_q;
    logic          fin_nxt;
    logic          acepta, ultimo;

    // ptr only moves on entry to LEER and is held in IDLE, so it doubles as
    // the ROM address and keeps the ROM input quiet between passes.
    assign address = ptr;
    assign ocupado = (estado != IDLE);
    assign acepta  = valido && listo;
    assign ultimo  = (ptr == fin_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= IDLE;
        else        estado <= estado_nxt;
    end

    // Next-state and end-of-pass pulse; parar beats everything else.
    always_comb begin
        estado_nxt = estado;
        fin_nxt    = 1'b0;
        case (estado)
            IDLE: begin
                if (start && !parar) estado_nxt = LEER;
            end
            LEER: begin
                estado_nxt = parar ? IDLE : ENTREGAR;
            end
            ENTREGAR: begin
                if (parar) begin
                    estado_nxt = IDLE;
                end else if (acepta) begin
                    if (ultimo && !modo_q) begin
                        estado_nxt = IDLE;
                        fin_nxt    = 1'b1;
                    end else begin
                        estado_nxt = LEER;
                    end
                end
            end
            default: estado_nxt = IDLE;
        endcase
    end

    // Datapath: latch range at start, capture ROM word, advance pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            ini_q  <= '0;
            fin_q  <= '0;
            modo_q <= 1'b0;
            dato   <= '0;
            valido <= 1'b0;
            fin    <= 1'b0;
        end else begin
            fin <= fin_nxt;
            case (estado)
                IDLE: begin
                    if (start && !parar) begin
                        ptr    <= dir_ini;
                        ini_q  <= dir_ini;
                        fin_q  <= dir_fin;
                        modo_q <= modo_ciclo;
                    end
                end
                LEER: begin
                    if (!parar) begin
                        dato   <= datos_rom;
                        valido <= 1'b1;
                    end
                end
                ENTREGAR: begin
                    if (parar) begin
                        valido <= 1'b0;
                    end else if (acepta) begin
                        valido <= 1'b0;
                        if (!ultimo)     ptr <= AW'(ptr + 1'b1);
                        else if (modo_q) ptr <= ini_q;
                    end
                end
                default: valido <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_rom.sv
// Directed bench for secuenciador_rom driving a rom4x4.
module tb_secuenciador_rom;

    logic       clk;
    logic       rst_n;
    logic       start, parar, modo_ciclo, listo;
    logic [1:0] dir_ini, dir_fin, address;
    logic [3:0] datos_rom, dato;
    logic       valido, ocupado, fin;

    int n_cmp = 0;
    int n_err = 0;

    // Expected ROM contents, by address.
    logic [3:0] rom_ref [4];

    secuenciador_rom #(.AW(2), .DW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .parar(parar),
        .modo_ciclo(modo_ciclo), .dir_ini(dir_ini), .dir_fin(dir_fin),
        .address(address), .datos_rom(datos_rom), .dato(dato),
        .valido(valido), .listo(listo), .ocupado(ocupado), .fin(fin)
    );

    rom4x4 #(.AW(2), .DW(4)) u_rom (.address(address), .datos(datos_rom));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start; returns in LEER for the first word.
    task automatic start_pass(input logic [1:0] ini, input logic [1:0] fn, input logic modo);
        dir_ini    = ini;
        dir_fin    = fn;
        modo_ciclo = modo;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; parar = 0; modo_ciclo = 0; listo = 1;
        dir_ini = 0; dir_fin = 0;
        tick(); tick();
        n_cmp++;
        if ({valido, dato, address, ocupado, fin} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_values: got v,d,a,o,f=%b exp 0", {valido, dato, address, ocupado, fin});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({valido, ocupado, fin} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_idle: got v,o,f=%b exp 000", {valido, ocupado, fin});
        end
    endtask

    task automatic test_basic();
        listo = 1'b1;
        start_pass(2'd0, 2'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({valido, address, ocupado, fin} !== {1'b0, 2'(i), 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL basic_leer%0d: got v,a,o,f=%b exp %b", i,
                         {valido, address, ocupado, fin}, {1'b0, 2'(i), 1'b1, 1'b0});
            end
            tick();
            n_cmp++;
            if ({valido, dato, address} !== {1'b1, rom_ref[i], 2'(i)}) begin
                n_err++;
                $display("FAIL basic_word%0d: got v,d,a=%b exp %b", i,
                         {valido, dato, address}, {1'b1, rom_ref[i], 2'(i)});
            end
            tick();
        end
        n_cmp++;
        if ({valido, ocupado, fin} !== 3'b001) begin
            n_err++;
            $display("FAIL basic_fin: got v,o,f=%b exp 001", {valido, ocupado, fin});
        end
        tick();
        n_cmp++;
        if ({ocupado, fin} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_fin_pulse: got o,f=%b exp 00", {ocupado, fin});
        end
    endtask

    task automatic test_wrap();
        logic [1:0] a;
        listo = 1'b1;
        start_pass(2'd2, 2'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            a = 2'(2 + i);
            tick();
            n_cmp++;
            if ({valido, dato, address, fin} !== {1'b1, rom_ref[a], a, 1'b0}) begin
                n_err++;
                $display("FAIL wrap_word%0d: got v,d,a,f=%b exp %b", i,
                         {valido, dato, address, fin}, {1'b1, rom_ref[a], a, 1'b0});
            end
            tick();
        end
        n_cmp++;
        if ({ocupado, fin} !== 2'b01) begin
            n_err++;
            $display("FAIL wrap_fin: got o,f=%b exp 01", {ocupado, fin});
        end
        // one-word range
        start_pass(2'd3, 2'd3, 1'b0);
        n_cmp++;
        if ({address, ocupado, fin} !== 4'b1110) begin
            n_err++;
            $display("FAIL single_leer: got a,o,f=%b exp 1110", {address, ocupado, fin});
        end
        tick();
        n_cmp++;
        if ({valido, dato} !== {1'b1, 4'h8}) begin
            n_err++;
            $display("FAIL single_word: got v,d=%b exp 11000", {valido, dato});
        end
        tick();
        n_cmp++;
        if ({valido, ocupado, fin} !== 3'b001) begin
            n_err++;
            $display("FAIL single_fin: got v,o,f=%b exp 001", {valido, ocupado, fin});
        end
        tick();
    endtask

    task automatic test_backpressure();
        listo = 1'b1;
        start_pass(2'd0, 2'd3, 1'b0);
        tick();               // 0x1 presented, accepted at next edge
        tick();               // LEER for address 1
        listo = 1'b0;
        tick();               // 0x2 presented
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({valido, dato, address, ocupado} !== {1'b1, 4'h2, 2'd1, 1'b1}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v,d,a,o=%b exp 1001001", i,
                         {valido, dato, address, ocupado});
            end
            if (i < 4) tick();
        end
        listo = 1'b1;
        tick();
        n_cmp++;
        if ({valido, address} !== {1'b0, 2'd2}) begin
            n_err++;
            $display("FAIL bp_release: got v,a=%b exp 010", {valido, address});
        end
        tick();
        n_cmp++;
        if ({valido, dato} !== {1'b1, 4'h4}) begin
            n_err++;
            $display("FAIL bp_next: got v,d=%b exp 10100", {valido, dato});
        end
        // abort coinciding with a handshake: no further word, no fin
        parar = 1'b1;
        tick();
        parar = 1'b0;
        n_cmp++;
        if ({valido, ocupado, fin} !== 3'b000) begin
            n_err++;
            $display("FAIL bp_abort: got v,o,f=%b exp 000", {valido, ocupado, fin});
        end
        tick();
    endtask

    task automatic test_loop_abort();
        listo = 1'b1;
        start_pass(2'd0, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({valido, dato, fin, ocupado} !== {1'b1, rom_ref[i % 2], 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL loop_word%0d: got v,d,f,o=%b exp %b", i,
                         {valido, dato, fin, ocupado}, {1'b1, rom_ref[i % 2], 1'b0, 1'b1});
            end
            if (i < 4) begin
                tick();
                n_cmp++;
                if ({valido, fin, ocupado} !== 3'b001) begin
                    n_err++;
                    $display("FAIL loop_gap%0d: got v,f,o=%b exp 001", i, {valido, fin, ocupado});
                end
            end
        end
        parar = 1'b1;
        tick();
        parar = 1'b0;
        n_cmp++;
        if ({valido, ocupado, fin} !== 3'b000) begin
            n_err++;
            $display("FAIL loop_abort: got v,o,f=%b exp 000", {valido, ocupado, fin});
        end
        tick();
        n_cmp++;
        if ({valido, ocupado, fin} !== 3'b000) begin
            n_err++;
            $display("FAIL loop_after: got v,o,f=%b exp 000", {valido, ocupado, fin});
        end
        // start and parar together in IDLE: parar wins
        dir_ini = 2'd0; dir_fin = 2'd0; start = 1'b1; parar = 1'b1;
        tick();
        start = 1'b0; parar = 1'b0;
        n_cmp++;
        if ({valido, ocupado} !== 2'b00) begin
            n_err++;
            $display("FAIL start_parar: got v,o=%b exp 00", {valido, ocupado});
        end
        tick();
    endtask

    task automatic test_ignored_start();
        listo = 1'b1;
        start_pass(2'd0, 2'd3, 1'b0);
        tick();               // 0x1 presented
        dir_ini = 2'd3; dir_fin = 2'd3; modo_ciclo = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if ({valido, address} !== {1'b0, 2'(i)}) begin
                n_err++;
                $display("FAIL ign_leer%0d: got v,a=%b exp %b", i, {valido, address}, {1'b0, 2'(i)});
            end
            tick();
            n_cmp++;
            if ({valido, dato} !== {1'b1, rom_ref[i]}) begin
                n_err++;
                $display("FAIL ign_word%0d: got v,d=%b exp %b", i, {valido, dato}, {1'b1, rom_ref[i]});
            end
            tick();
        end
        n_cmp++;
        if ({ocupado, fin} !== 2'b01) begin
            n_err++;
            $display("FAIL ign_fin: got o,f=%b exp 01", {ocupado, fin});
        end
        tick();
    endtask

    task automatic test_async_reset();
        listo = 1'b1;
        start_pass(2'd2, 2'd3, 1'b0);
        tick();               // 0x4 presented at address 2
        listo = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({valido, dato, address, ocupado, fin} !== 9'd0) begin
            n_err++;
            $display("FAIL async_reset: got v,d,a,o,f=%b exp 0", {valido, dato, address, ocupado, fin});
        end
        tick();
        #2 rst_n = 1'b1;
        listo = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({valido, address, ocupado, fin} !== 5'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: got v,a,o,f=%b exp 0", {valido, address, ocupado, fin});
        end
        start_pass(2'd1, 2'd1, 1'b0);
        tick();
        n_cmp++;
        if ({valido, dato, address} !== {1'b1, 4'h2, 2'd1}) begin
            n_err++;
            $display("FAIL post_reset_pass: got v,d,a=%b exp 1001001", {valido, dato, address});
        end
        tick();
        n_cmp++;
        if ({ocupado, fin} !== 2'b01) begin
            n_err++;
            $display("FAIL post_reset_fin: got o,f=%b exp 01", {ocupado, fin});
        end
    endtask

    initial begin
        rom_ref[0] = 4'h1; rom_ref[1] = 4'h2; rom_ref[2] = 4'h4; rom_ref[3] = 4'h8;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_loop_abort();
        test_ignored_start();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
